spi_cmd_facade: RTL and testbench

- Command-driven SPI master front-end; next generation of the fixed-mode 8-bit SPI facade.
- Adds runtime-selectable CPOL/CPHA/CS polarity/auto-CS, an SCLK divider, parametrised word width, explicit CS assert/deassert commands, and a valid/ready command handshake.
- Sits between the command dispatcher and the Bus Pirate pin bank (bp_din/bp_dout).
- Contains its own shift engine.

---
 rtl/spi_facade_pkg.sv | 35 +++
 rtl/spi_half_tick.sv | 39 +++
 rtl/spi_cmd_facade.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_cmd_facade.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_facade_pkg.sv
// Shared opcodes, FSM encoding and reset-default configuration for the SPI command facade.
package spi_facade_pkg;

  // Command opcodes carried on cmd_opcode
  localparam logic [1:0] OP_DATA   = 2'd0;
  localparam logic [1:0] OP_CS_ON  = 2'd1;
  localparam logic [1:0] OP_CS_OFF = 2'd2;
  localparam logic [1:0] OP_CFG    = 2'd3;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_e;

  // Latched SPI mode bits; cspol=1 means CS is active-low
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic cspol;
    logic autocs;
  } mode_t;

  // Mode after reset: SCLK idles high, leading-edge sampling, active-low CS, auto framing.
  // The clock divider resets to zero (SCLK = clock/2).
  localparam mode_t MODE_RST = '{cpol: 1'b1, cpha: 1'b0, cspol: 1'b1, autocs: 1'b1};

  // Pin level for a logical CS state under the given polarity
  function automatic logic cs_level(input logic active, input logic active_low);
    return active_low ? ~active : active;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: one-cycle tick every div+1 cycles while enabled, idle and cleared otherwise.
module spi_half_tick #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_c
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic [DIV_WIDTH-1:0] cur_c;

  // Down-count; the first enabled cycle starts from div so the divider latched at accept applies at once
  always_comb begin
    cnt_d  = '0;
    run_d  = 1'b0;
    cur_c  = run_q ? cnt_q : div_i;
    tick_c = en_i && (cur_c == '0);
    if (en_i) begin
      run_d = 1'b1;
      cnt_d = (cur_c == '0) ? div_i : cur_c - DIV_WIDTH'(1);
    end
  end

  // Counter state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/spi_cmd_facade.sv
// Command-driven SPI master: valid/ready command port, runtime mode/divider, shift engine on the pin bank.
module spi_cmd_facade
  import spi_facade_pkg::*;
#(
  parameter int unsigned BP_PINS    = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned MOSI_PIN   = 0,
  parameter int unsigned SCLK_PIN   = 1,
  parameter int unsigned MISO_PIN   = 2,
  parameter int unsigned CS_PIN     = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_cspol,
  input  logic                  cfg_autocs,
  input  logic [DIV_WIDTH-1:0]  cfg_clkdiv,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [BP_PINS-1:0]    bp_din,
  input  logic [BP_PINS-1:0]    bp_dout
);

  localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  state_e                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  cs_manual_q, cs_manual_d;
  logic                  framed_q, framed_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_pin_q, cs_pin_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  tick_c;
  logic                  accept_c;
  logic                  sample_c;
  logic                  cs_act_c;
  logic                  miso_c;
  logic                  unused_pins;

  assign miso_c      = bp_dout[MISO_PIN];
  assign unused_pins = ^bp_dout;

  // Half-period timer runs for the whole framed transfer so setup, shift and hold share one cadence
  spi_half_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_half_tick (
    .clock (clock),
    .reset (reset),
    .en_i  (state_q != ST_IDLE),
    .div_i (div_q),
    .tick_c(tick_c)
  );

  // Next-state, shift datapath and registered pin levels
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    div_d       = div_q;
    cs_manual_d = cs_manual_q;
    framed_d    = framed_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_pin_d    = cs_pin_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cs_act_c    = 1'b0;
    accept_c    = cmd_valid && ready_q;
    // Even edge index is the leading edge; CPHA picks which edge samples MISO
    sample_c    = (~edge_q[0]) ^ mode_q.cpha;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          mode_d.cpol   = cfg_cpol;
          mode_d.cpha   = cfg_cpha;
          mode_d.cspol  = cfg_cspol;
          mode_d.autocs = cfg_autocs;
          div_d         = cfg_clkdiv;
          case (cmd_opcode)
            OP_DATA: begin
              framed_d = mode_d.autocs && !cs_manual_q;
              tx_d     = cmd_data;
              rx_d     = '0;
              edge_d   = '0;
              if (framed_d) begin
                state_d = ST_CS_SETUP;
              end else begin
                state_d = ST_SHIFT;
                if (!mode_d.cpha) begin
                  mosi_d = cmd_data[DATA_WIDTH-1];
                  tx_d   = cmd_data << 1;
                end
              end
            end
            OP_CS_ON:  cs_manual_d = 1'b1;
            OP_CS_OFF: cs_manual_d = 1'b0;
            OP_CFG:    ;
            default:   ;
          endcase
        end
      end
      ST_CS_SETUP: begin
        if (tick_c) begin
          state_d = ST_SHIFT;
          if (!mode_q.cpha) begin
            mosi_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample_c) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], miso_c};
          end else begin
            mosi_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end
          if (edge_q == LAST_EDGE) begin
            edge_d  = '0;
            state_d = framed_q ? ST_CS_HOLD : ST_IDLE;
          end
        end
      end
      ST_CS_HOLD: begin
        if (tick_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // MOSI is only driven while shifting; SCLK rests at the latched polarity outside SHIFT
    if (state_d != ST_SHIFT) begin
      mosi_d = 1'b0;
    end
    if (state_q != ST_SHIFT) begin
      sclk_d = mode_d.cpol;
    end

    case (state_d)
      ST_IDLE:  cs_act_c = cs_manual_d;
      ST_SHIFT: cs_act_c = cs_manual_d | framed_d;
      default:  cs_act_c = 1'b1;
    endcase
    cs_pin_d = cs_level(cs_act_c, mode_d.cspol);

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;

    // Response is issued on the way back into IDLE, including a sample taken on the final edge
    if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rx_d;
    end
  end

  // State and output registers; reset parks the pins at idle with CS inactive
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_RST;
      div_q       <= '0;
      cs_manual_q <= 1'b0;
      framed_q    <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      edge_q      <= '0;
      sclk_q      <= MODE_RST.cpol;
      mosi_q      <= 1'b0;
      cs_pin_q    <= cs_level(1'b0, MODE_RST.cspol);
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      cs_manual_q <= cs_manual_d;
      framed_q    <= framed_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      edge_q      <= edge_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_pin_q    <= cs_pin_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Pin bank wiring; unused drive bits stay low
  always_comb begin
    bp_din           = '0;
    bp_din[MOSI_PIN] = mosi_q;
    bp_din[SCLK_PIN] = sclk_q;
    bp_din[CS_PIN]   = cs_pin_q;
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_cmd_facade.sv
// Directed bench for spi_cmd_facade: 8-bit instance plus a 16-bit instance for back-to-back commands.
module tb_spi_cmd_facade;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, busy;
  logic [1:0]  cmd_opcode;
  logic [7:0]  cmd_data, rsp_data, cfg_clkdiv;
  logic        cfg_cpol, cfg_cpha, cfg_cspol, cfg_autocs;
  logic [4:0]  bp_din, bp_dout;

  logic        v16, r16, rv16, busy16;
  logic [1:0]  op16;
  logic [15:0] d16, rd16;
  logic [4:0]  din16, dout16;

  logic        loop_sel;
  logic        slave_bit;
  logic [7:0]  slv_pat;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_lat = 0;
  logic [7:0] rsp_last = 8'h00;
  int cs_low = 0, cs_high = 0;
  int tog_cnt = 0, rise_cnt = 0, fall_cnt = 0, fall_mosi1 = 0, bad_gap = 0;
  int frame_falls = 0, frame_tog = 0, last_tog = 0, gap_exp = 1;
  logic prev_sclk = 1'b1;
  int acc16 = 0, acc16_cyc = 0, r16_cnt = 0, r16_l0 = 0, r16_l1 = 0;
  logic [15:0] r16_d0 = 16'h0, r16_d1 = 16'h0;

  always #5 clock = ~clock;

  assign bp_dout = {2'b00, (loop_sel ? bp_din[0] : slave_bit), 2'b00};
  assign dout16  = {2'b00, din16[0], 2'b00};

  // Mode-3 slave: presents the next pattern bit after each SCLK fall inside the CS frame
  always_comb begin
    slave_bit = 1'b0;
    if (frame_falls >= 1 && frame_falls <= 8) slave_bit = slv_pat[3'(8 - frame_falls)];
  end

  spi_cmd_facade #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_cspol(cfg_cspol), .cfg_autocs(cfg_autocs), .cfg_clkdiv(cfg_clkdiv),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .bp_din(bp_din), .bp_dout(bp_dout)
  );

  spi_cmd_facade #(.DATA_WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .cmd_valid(v16), .cmd_ready(r16),
    .cmd_opcode(op16), .cmd_data(d16), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_cspol(cfg_cspol), .cfg_autocs(cfg_autocs), .cfg_clkdiv(cfg_clkdiv),
    .rsp_valid(rv16), .rsp_data(rd16), .busy(busy16), .bp_din(din16), .bp_dout(dout16)
  );

  // Cycle monitor sampled mid-cycle: accepts, responses, CS and SCLK activity
  always @(negedge clock) begin
    cyc++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_lat  = cyc - acc_cyc - 1;
      rsp_last = rsp_data;
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (!bp_din[3]) cs_low++; else cs_high++;
    if (bp_din[3]) begin
      frame_falls = 0;
      frame_tog   = 0;
    end else if (bp_din[1] != prev_sclk) begin
      tog_cnt++;
      if (frame_tog > 0 && (cyc - last_tog) != gap_exp) bad_gap++;
      frame_tog++;
      last_tog = cyc;
      if (bp_din[1]) rise_cnt++;
      else begin
        fall_cnt++;
        frame_falls++;
        if (bp_din[0]) fall_mosi1++;
      end
    end
    prev_sclk = bp_din[1];
    if (rv16) begin
      if (r16_cnt == 0) begin r16_d0 = rd16; r16_l0 = cyc - acc16_cyc - 1; end
      else if (r16_cnt == 1) begin r16_d1 = rd16; r16_l1 = cyc - acc16_cyc - 1; end
      r16_cnt++;
    end
    if (v16 && r16) begin
      acc16++;
      acc16_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic cpol, input logic cpha, input logic cspol,
                         input logic autocs, input logic [7:0] div);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_cspol = cspol; cfg_autocs = autocs; cfg_clkdiv = div;
  endtask

  // Present one command on the 8-bit DUT and return just after its accept edge
  task automatic send(input logic [1:0] op, input logic [7:0] data);
    int n;
    n = 0;
    @(posedge clock); #1;
    cmd_opcode = op; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clock);
    while (!cmd_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check("send_accept", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_rsp(input int base);
    int n;
    n = 0;
    while (rsp_cnt == base && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("rsp_arrived", 32'(rsp_cnt != base), 32'd1);
  endtask

  initial begin
    int s_cs, s_rise, s_tog, s_fm1, s_gap, s_rsp, n;
    loop_sel = 1'b1; slv_pat = 8'h3C;
    v16 = 1'b0; op16 = 2'd0; d16 = 16'h0;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = 2'd0; cmd_data = 8'h00;
    set_cfg(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);

    // Reset held with random command traffic
    repeat (6) begin
      @(posedge clock); #1;
      cmd_valid = 1'($urandom); cmd_opcode = 2'($urandom); cmd_data = 8'($urandom);
      set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    check("rst_pins", 32'(bp_din), 32'h0A);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_no_rsp", 32'(rsp_cnt), 32'd0);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    reset = 1'b1;

    // Mode 0 loopback, auto-CS, div 0
    set_cfg(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    send(2'd3, 8'h00);
    check("m0_cfg_pins", 32'(bp_din), 32'h08);
    s_cs = cs_low; s_rise = rise_cnt; s_rsp = rsp_cnt;
    send(2'd0, 8'hA5);
    wait_rsp(s_rsp);
    check("m0_rsp", 32'(rsp_last), 32'hA5);
    check("m0_lat", 32'(rsp_lat), 32'd18);
    check("m0_cs_low", 32'(cs_low - s_cs), 32'd18);
    check("m0_rises", 32'(rise_cnt - s_rise), 32'd8);

    // Mode 3, div 3, slave returns 0x3C
    loop_sel = 1'b0; gap_exp = 4;
    set_cfg(1'b1, 1'b1, 1'b1, 1'b1, 8'd3);
    send(2'd3, 8'h00);
    check("m3_sclk_idle", 32'(bp_din[1]), 32'd1);
    s_tog = tog_cnt; s_rise = rise_cnt; s_fm1 = fall_mosi1; s_gap = bad_gap; s_rsp = rsp_cnt;
    send(2'd0, 8'hFF);
    wait_rsp(s_rsp);
    check("m3_rsp", 32'(rsp_last), 32'h3C);
    check("m3_lat", 32'(rsp_lat), 32'd72);
    check("m3_edges", 32'(tog_cnt - s_tog), 32'd16);
    check("m3_rises", 32'(rise_cnt - s_rise), 32'd8);
    check("m3_mosi_ones", 32'(fall_mosi1 - s_fm1), 32'd8);
    check("m3_edge_gap", 32'(bad_gap - s_gap), 32'd0);
    loop_sel = 1'b1;

    // Manual CS across two words
    set_cfg(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    send(2'd1, 8'h00);
    check("man_cs_on", 32'(bp_din[3]), 32'd0);
    s_cs = cs_high; s_rsp = rsp_cnt;
    send(2'd0, 8'h12);
    wait_rsp(s_rsp);
    check("man_rsp1", 32'(rsp_last), 32'h12);
    check("man_lat1", 32'(rsp_lat), 32'd16);
    s_rsp = rsp_cnt;
    send(2'd0, 8'h34);
    wait_rsp(s_rsp);
    check("man_rsp2", 32'(rsp_last), 32'h34);
    check("man_lat2", 32'(rsp_lat), 32'd16);
    check("man_cs_steady", 32'(cs_high - s_cs), 32'd0);
    send(2'd2, 8'h00);
    check("man_cs_off", 32'(bp_din[3]), 32'd1);

    // Reset part-way through a framed transfer
    s_rsp = rsp_cnt;
    send(2'd0, 8'hC3);
    repeat (11) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_pins", 32'(bp_din), 32'h0A);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (30) @(posedge clock);
    check("mid_rst_no_rsp", 32'(rsp_cnt), 32'(s_rsp));
    s_rsp = rsp_cnt;
    send(2'd0, 8'h5A);
    wait_rsp(s_rsp);
    check("post_rst_rsp", 32'(rsp_last), 32'h5A);
    check("post_rst_lat", 32'(rsp_lat), 32'd18);

    // 16-bit instance with valid held high across two queued words
    @(posedge clock); #1;
    v16 = 1'b1; op16 = 2'd0; d16 = 16'hBEEF;
    n = 0;
    while (acc16 < 1 && n < 200) begin @(posedge clock); #1; n++; end
    d16 = 16'h1234;
    while (acc16 < 2 && n < 400) begin @(posedge clock); #1; n++; end
    v16 = 1'b0;
    n = 0;
    while (r16_cnt < 2 && n < 200) begin @(negedge clock); n++; end
    repeat (40) @(posedge clock);
    check("w16_accepts", 32'(acc16), 32'd2);
    check("w16_rsp1", 32'(r16_d0), 32'hBEEF);
    check("w16_lat1", 32'(r16_l0), 32'd34);
    check("w16_rsp2", 32'(r16_d1), 32'h1234);
    check("w16_lat2", 32'(r16_l1), 32'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
